// File: rtl/gpu_bus_pkg.sv
// rtl/gpu_bus_pkg.sv - shared types and default sizing for the GPU interconnect bus scheduler
package gpu_bus_pkg;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_BUSY = 1'b1
    } arb_state_e;

    localparam int BUS_NUM_MASTERS    = 4;
    localparam int BUS_MAX_BURST      = 8;
    localparam int BUS_TIMEOUT_CYCLES = 64;

endpackage

// File: rtl/rr_priority_picker.sv
// rtl/rr_priority_picker.sv - combinational round-robin pick starting at ptr, skipping excluded requesters
module rr_priority_picker #(
    parameter int N     = 4,
    parameter int IDX_W = 2
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    input  logic [N-1:0]     exclude,
    output logic             valid,
    output logic [N-1:0]     onehot,
    output logic [IDX_W-1:0] index
);

    logic [N-1:0] cand;

    assign cand = req & ~exclude;

    always_comb begin
        int j;
        valid  = 1'b0;
        onehot = '0;
        index  = '0;
        j      = 0;
        for (int i = 0; i < N; i++) begin
            // ptr is always below N, so one subtraction is enough to wrap
            j = int'(ptr) + i;
            if (j >= N) j = j - N;
            if (!valid && cand[j]) begin
                valid     = 1'b1;
                onehot[j] = 1'b1;
                index     = IDX_W'(j);
            end
        end
    end

endmodule

// File: rtl/bus_scheduler.sv
// rtl/bus_scheduler.sv - registered round-robin bus owner with burst limit and hung-slave timeout
module bus_scheduler
    import gpu_bus_pkg::*;
#(
    parameter int NUM_MASTERS    = BUS_NUM_MASTERS,
    parameter int MAX_BURST      = BUS_MAX_BURST,
    parameter int TIMEOUT_CYCLES = BUS_TIMEOUT_CYCLES,
    parameter int IDX_W          = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NUM_MASTERS-1:0] i_requests,
    input  logic [NUM_MASTERS-1:0] i_lock,
    input  logic                   i_slave_done,
    output logic [NUM_MASTERS-1:0] o_grants,
    output logic                   o_grant_valid,
    output logic [IDX_W-1:0]       o_grant_index,
    output logic                   o_timeout,
    output logic [IDX_W-1:0]       o_timeout_index
);

    localparam int BEAT_W = $clog2(MAX_BURST) + 1;
    localparam int TO_W   = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    arb_state_e        state;
    logic [IDX_W-1:0]  owner;
    logic [IDX_W-1:0]  rr_ptr;
    logic [BEAT_W-1:0] beat_cnt;
    logic [TO_W-1:0]   to_cnt;

    logic              owner_req;
    logic [IDX_W-1:0]  next_ptr;
    logic              release_now;
    logic              timeout_now;
    logic              keep_done;

    logic [IDX_W-1:0]       pick_ptr;
    logic [NUM_MASTERS-1:0] pick_excl;
    logic                   pick_valid;
    logic [NUM_MASTERS-1:0] pick_onehot;
    logic [IDX_W-1:0]       pick_index;

    assign owner_req     = i_requests[owner];
    assign next_ptr      = (owner == IDX_W'(NUM_MASTERS - 1)) ? '0 : owner + 1'b1;
    assign o_grant_index = owner;

    // While busy the picker is only consulted on release, so aim it past the current owner
    assign pick_ptr  = (state == ARB_BUSY) ? next_ptr : rr_ptr;
    assign pick_excl = (state == ARB_BUSY) ? o_grants : '0;

    rr_priority_picker #(
        .N     (NUM_MASTERS),
        .IDX_W (IDX_W)
    ) u_picker (
        .req     (i_requests),
        .ptr     (pick_ptr),
        .exclude (pick_excl),
        .valid   (pick_valid),
        .onehot  (pick_onehot),
        .index   (pick_index)
    );

    always_comb begin
        release_now = 1'b0;
        timeout_now = 1'b0;
        keep_done   = 1'b0;
        if (state == ARB_BUSY) begin
            if (!owner_req) begin
                release_now = 1'b1;
            end else if (i_slave_done) begin
                if (!i_lock[owner] || beat_cnt == BEAT_W'(MAX_BURST - 1)) release_now = 1'b1;
                else                                                      keep_done   = 1'b1;
            end else if (to_cnt == TO_W'(TIMEOUT_CYCLES - 1)) begin
                release_now = 1'b1;
                timeout_now = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= ARB_IDLE;
            owner           <= '0;
            rr_ptr          <= '0;
            beat_cnt        <= '0;
            to_cnt          <= '0;
            o_grants        <= '0;
            o_grant_valid   <= 1'b0;
            o_timeout       <= 1'b0;
            o_timeout_index <= '0;
        end else begin
            o_timeout <= 1'b0;
            case (state)
                ARB_IDLE: begin
                    if (pick_valid) begin
                        state         <= ARB_BUSY;
                        owner         <= pick_index;
                        o_grants      <= pick_onehot;
                        o_grant_valid <= 1'b1;
                        beat_cnt      <= '0;
                        to_cnt        <= '0;
                    end
                end
                ARB_BUSY: begin
                    if (release_now) begin
                        rr_ptr   <= next_ptr;
                        beat_cnt <= '0;
                        to_cnt   <= '0;
                        if (timeout_now) begin
                            o_timeout       <= 1'b1;
                            o_timeout_index <= owner;
                        end
                        if (pick_valid) begin
                            owner    <= pick_index;
                            o_grants <= pick_onehot;
                        end else if (!owner_req) begin
                            state         <= ARB_IDLE;
                            owner         <= '0;
                            o_grants      <= '0;
                            o_grant_valid <= 1'b0;
                        end
                        // else: sole requester is re-granted with fresh counters
                    end else if (keep_done) begin
                        beat_cnt <= beat_cnt + 1'b1;
                        to_cnt   <= '0;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
                end
                default: state <= ARB_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bus_scheduler.sv
// tb/tb_bus_scheduler.sv - self-checking bench for bus_scheduler
module tb_bus_scheduler;

    logic       clk;
    logic       rst_n;
    logic [3:0] i_requests;
    logic [3:0] i_lock;
    logic       i_slave_done;
    logic [3:0] o_grants;
    logic       o_grant_valid;
    logic [1:0] o_grant_index;
    logic       o_timeout;
    logic [1:0] o_timeout_index;

    bus_scheduler #(
        .NUM_MASTERS    (4),
        .MAX_BURST      (8),
        .TIMEOUT_CYCLES (64)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .i_requests      (i_requests),
        .i_lock          (i_lock),
        .i_slave_done    (i_slave_done),
        .o_grants        (o_grants),
        .o_grant_valid   (o_grant_valid),
        .o_grant_index   (o_grant_index),
        .o_timeout       (o_timeout),
        .o_timeout_index (o_timeout_index)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] req;
        logic [3:0] lock;
        logic       done;
        logic [3:0] grants;
    } vec_t;

    typedef struct {
        logic [3:0] grants;
        logic       timeout;
        logic [1:0] to_idx;
        string      tag;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    function automatic logic [1:0] oh2idx(input logic [3:0] oh);
        logic [1:0] r;
        r = 2'd0;
        for (int k = 0; k < 4; k++) if (oh[k]) r = 2'(k);
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic compare_out();
        exp_t e;
        if (sb.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL scoreboard_empty: got 0 entries expected 1");
            return;
        end
        e = sb.pop_front();
        check({e.tag, "_grants"},    32'(o_grants),        32'(e.grants));
        check({e.tag, "_valid"},     32'(o_grant_valid),   32'(|e.grants));
        check({e.tag, "_index"},     32'(o_grant_index),   32'(oh2idx(e.grants)));
        check({e.tag, "_timeout"},   32'(o_timeout),       32'(e.timeout));
        check({e.tag, "_to_index"},  32'(o_timeout_index), 32'(e.to_idx));
    endtask

    task automatic apply(input logic [3:0] req, input logic [3:0] lock, input logic done,
                         input logic [3:0] eg, input logic et, input logic [1:0] eti,
                         input string tag);
        exp_t e;
        i_requests   = req;
        i_lock       = lock;
        i_slave_done = done;
        e.grants  = eg;
        e.timeout = et;
        e.to_idx  = eti;
        e.tag     = tag;
        sb.push_back(e);
        @(posedge clk);
        #1;
        compare_out();
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_grants"},   32'(o_grants),        32'd0);
        check({tag, "_valid"},    32'(o_grant_valid),   32'd0);
        check({tag, "_index"},    32'(o_grant_index),   32'd0);
        check({tag, "_timeout"},  32'(o_timeout),       32'd0);
        check({tag, "_to_index"}, 32'(o_timeout_index), 32'd0);
    endtask

    vec_t vecs[20];

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vecs[0]  = '{4'b1010, 4'b0000, 1'b0, 4'b0010};
        vecs[1]  = '{4'b1010, 4'b0000, 1'b1, 4'b1000};
        vecs[2]  = '{4'b1010, 4'b0000, 1'b1, 4'b0010};
        vecs[3]  = '{4'b1111, 4'b0000, 1'b1, 4'b0100};
        vecs[4]  = '{4'b1111, 4'b0000, 1'b1, 4'b1000};
        vecs[5]  = '{4'b1111, 4'b0000, 1'b1, 4'b0001};
        vecs[6]  = '{4'b1111, 4'b0000, 1'b1, 4'b0010};
        vecs[7]  = '{4'b1111, 4'b0000, 1'b1, 4'b0100};
        vecs[8]  = '{4'b1111, 4'b0000, 1'b1, 4'b1000};
        vecs[9]  = '{4'b1111, 4'b0000, 1'b1, 4'b0001};
        vecs[10] = '{4'b1111, 4'b0000, 1'b0, 4'b0001};
        vecs[11] = '{4'b1110, 4'b0000, 1'b0, 4'b0010};
        vecs[12] = '{4'b0000, 4'b0000, 1'b0, 4'b0000};
        vecs[13] = '{4'b0000, 4'b0000, 1'b0, 4'b0000};
        vecs[14] = '{4'b0100, 4'b0000, 1'b0, 4'b0100};
        vecs[15] = '{4'b0100, 4'b0100, 1'b1, 4'b0100};
        vecs[16] = '{4'b0101, 4'b0100, 1'b1, 4'b0100};
        vecs[17] = '{4'b0101, 4'b0000, 1'b1, 4'b0001};
        vecs[18] = '{4'b0000, 4'b0000, 1'b0, 4'b0000};
        vecs[19] = '{4'b0000, 4'b1111, 1'b1, 4'b0000};

        rst_n        = 1'b0;
        i_requests   = '0;
        i_lock       = '0;
        i_slave_done = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("reset");
        rst_n = 1'b1;

        for (int v = 0; v < 20; v++)
            apply(vecs[v].req, vecs[v].lock, vecs[v].done, vecs[v].grants, 1'b0, 2'd0,
                  $sformatf("vec%0d", v));

        // locked burst: 8 beats, sole-requester re-grant, then a fresh 8-beat burst
        apply(4'b0100, 4'b0100, 1'b0, 4'b0100, 1'b0, 2'd0, "burst_grant");
        for (int b = 1; b <= 8; b++)
            apply(4'b0100, 4'b0100, 1'b1, 4'b0100, 1'b0, 2'd0, $sformatf("burst_a%0d", b));
        for (int b = 1; b <= 7; b++)
            apply(4'b0110, 4'b0100, 1'b1, 4'b0100, 1'b0, 2'd0, $sformatf("burst_b%0d", b));
        apply(4'b0110, 4'b0100, 1'b1, 4'b0010, 1'b0, 2'd0, "burst_limit");

        // owner 1 abandons, master 0 granted and then times out
        apply(4'b0001, 4'b0000, 1'b0, 4'b0001, 1'b0, 2'd0, "to0_grant");
        for (int c = 1; c <= 63; c++)
            apply(4'b0011, 4'b0000, 1'b0, 4'b0001, 1'b0, 2'd0, $sformatf("to0_wait%0d", c));
        apply(4'b0011, 4'b0000, 1'b0, 4'b0010, 1'b1, 2'd0, "to0_expire");

        // done coinciding with expiry wins
        for (int c = 1; c <= 63; c++)
            apply(4'b0011, 4'b0000, 1'b0, 4'b0010, 1'b0, 2'd0, $sformatf("coin_wait%0d", c));
        apply(4'b0011, 4'b0000, 1'b1, 4'b0001, 1'b0, 2'd0, "coin_done");

        // master 1 alone times out and is re-granted
        apply(4'b0010, 4'b0000, 1'b0, 4'b0010, 1'b0, 2'd0, "to1_grant");
        for (int c = 1; c <= 63; c++)
            apply(4'b0010, 4'b0000, 1'b0, 4'b0010, 1'b0, 2'd0, $sformatf("to1_wait%0d", c));
        apply(4'b0010, 4'b0000, 1'b0, 4'b0010, 1'b1, 2'd1, "to1_expire");
        apply(4'b0010, 4'b0010, 1'b1, 4'b0010, 1'b0, 2'd1, "to1_beat");

        // asynchronous reset mid-burst
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("async_rst");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        apply(4'b1111, 4'b0000, 1'b0, 4'b0001, 1'b0, 2'd0, "post_rst_grant");
        apply(4'b1111, 4'b0000, 1'b1, 4'b0010, 1'b0, 2'd0, "post_rst_next");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
